// File: rtl/boolean_alu_pipe_if.sv
// Valid/ready stream bundle for boolean_alu_pipe: operand beat in, result beat out.
// The slave modport is the unit's view; the master modport is the producer/consumer side.
interface boolean_alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;
  logic             acc_busy;

  modport slave (
    input  in_valid, a, b, op, acc_mode, out_ready,
    output in_ready, out_valid, y, y_zero, y_ones, acc_busy
  );

  modport master (
    output in_valid, a, b, op, acc_mode, out_ready,
    input  in_ready, out_valid, y, y_zero, y_ones, acc_busy
  );
endinterface

// File: rtl/boolean_alu_pipe.sv
// Registered bitwise boolean unit with valid/ready flow control on both sides.
// Define BOOLEAN_ALU_ACC_EN to build the XOR-fold accumulate frame mode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no frame open; single beats go straight to y
// ST_ACC  | accumulate frame open; acc holds the fold of cnt beats
module boolean_alu_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  boolean_alu_pipe_if.slave    bus
);

  function automatic logic [WIDTH-1:0] bool_fn(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & z;
      3'd1:    r = x | z;
      3'd2:    r = x ^ z;
      3'd3:    r = ~(x ^ z);
      3'd4:    r = ~(x & z);
      3'd5:    r = ~(x | z);
      3'd6:    r = x & ~z;
      default: r = x;
    endcase
    return r;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_zero_q, y_zero_d;
  logic             y_ones_q, y_ones_d;
  logic             accept;
  logic             take;

  // in_ready deliberately sees only the output register, never in_valid
  assign bus.in_ready  = ~out_valid_q | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign take          = out_valid_q & bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_zero    = y_zero_q;
  assign bus.y_ones    = y_ones_q;

`ifdef BOOLEAN_ALU_ACC_EN
  localparam int CNT_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_DEPTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_lat_q, op_lat_d;
  logic [WIDTH-1:0] beat_res;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_lat_d    = op_lat_q;
    y_d         = y_q;
    out_valid_d = out_valid_q & ~take;
    // inside a frame the op latched on its first beat governs every beat
    beat_res    = bool_fn((state_q == ST_ACC) ? op_lat_q : bus.op, bus.a, bus.b);

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.acc_mode) begin
            acc_d    = beat_res;
            cnt_d    = CNT_W'(1);
            op_lat_d = bus.op;
            state_d  = ST_ACC;
          end else begin
            y_d         = beat_res;
            out_valid_d = 1'b1;
          end
        end
        ST_ACC: begin
          if (cnt_q == CNT_LAST) begin
            y_d         = acc_q ^ beat_res;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            acc_d = acc_q ^ beat_res;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_lat_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_lat_q <= op_lat_d;
    end
  end

  assign bus.acc_busy = (state_q == ST_ACC);
`else
  localparam int unused_acc_depth = ACC_DEPTH;
  logic unused_acc_mode;
  assign unused_acc_mode = bus.acc_mode;

  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q & ~take;
    if (accept) begin
      y_d         = bool_fn(bus.op, bus.a, bus.b);
      out_valid_d = 1'b1;
    end
  end

  assign bus.acc_busy = 1'b0;
`endif

  // flags derive from y_d so they load on the same edge and always agree with y
  always_comb begin
    y_zero_d = (y_d == '0);
    y_ones_d = &y_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_zero_q    <= 1'b1;
      y_ones_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_zero_q    <= y_zero_d;
      y_ones_q    <= y_ones_d;
    end
  end

endmodule

// File: tb/tb_boolean_alu_pipe.sv
// Self-checking bench for boolean_alu_pipe: directed cases plus random streams
// against a frame-level reference model; follows BOOLEAN_ALU_ACC_EN like the design.
module tb_boolean_alu_pipe;
  localparam int WIDTH     = 8;
  localparam int ACC_DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  boolean_alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  boolean_alu_pipe #(.WIDTH(WIDTH), .ACC_DEPTH(ACC_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: pending output plus the list of beat results of the open frame
  logic             mdl_valid;
  logic [WIDTH-1:0] mdl_y;
  logic [WIDTH-1:0] frame_q[$];
  logic [2:0]       frame_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    case (sel)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return x ^ z;
      3'd3:    return ~(x ^ z);
      3'd4:    return ~(x & z);
      3'd5:    return ~(x | z);
      3'd6:    return x & ~z;
      default: return x;
    endcase
  endfunction

  task automatic model_reset();
    mdl_valid = 1'b0;
    mdl_y     = '0;
    frame_q.delete();
  endtask

  task automatic check_outputs(input string where);
    logic exp_busy;
    exp_busy = 1'b0;
`ifdef BOOLEAN_ALU_ACC_EN
    exp_busy = (frame_q.size() != 0);
`endif
    chk({where, ".out_valid"}, 32'(bus.out_valid), 32'(mdl_valid));
    chk({where, ".y"},         32'(bus.y),         32'(mdl_y));
    chk({where, ".y_zero"},    32'(bus.y_zero),    32'(mdl_y == '0));
    chk({where, ".y_ones"},    32'(bus.y_ones),    32'(mdl_y == {WIDTH{1'b1}}));
    chk({where, ".acc_busy"},  32'(bus.acc_busy),  32'(exp_busy));
    chk({where, ".in_ready"},  32'(bus.in_ready),  32'(!mdl_valid || bus.out_ready));
  endtask

  // one clock: drive at negedge, advance the model, check just after the posedge
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [2:0] opv, input logic am, input logic ordy);
    logic             acc_ok;
    logic [WIDTH-1:0] r;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.op        = opv;
    bus.acc_mode  = am;
    bus.out_ready = ordy;
    #1;
    chk("pre.in_ready", 32'(bus.in_ready), 32'(!mdl_valid || ordy));
    acc_ok = iv && (!mdl_valid || ordy);
    if (mdl_valid && ordy) mdl_valid = 1'b0;
    if (acc_ok) begin
`ifdef BOOLEAN_ALU_ACC_EN
      if (frame_q.size() == 0 && !am) begin
        mdl_valid = 1'b1;
        mdl_y     = ref_fn(opv, av, bv);
      end else begin
        if (frame_q.size() == 0) frame_op = opv;
        frame_q.push_back(ref_fn(frame_op, av, bv));
        if (frame_q.size() == ACC_DEPTH) begin
          r = '0;
          foreach (frame_q[i]) r = r ^ frame_q[i];
          frame_q.delete();
          mdl_valid = 1'b1;
          mdl_y     = r;
        end
      end
`else
      mdl_valid = 1'b1;
      mdl_y     = am ? ref_fn(opv, av, bv) : ref_fn(opv, av, bv);
`endif
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    logic [2:0]       ops[4];
    logic [WIDTH-1:0] exp_sb[4];
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.acc_mode  = 1'b0;
    bus.out_ready = 1'b1;
    frame_op      = '0;
    model_reset();
    #23 rst_n = 1'b1;

    // reset values
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.y",         32'(bus.y),         32'd0);
    chk("rst.y_zero",    32'(bus.y_zero),    32'd1);
    chk("rst.y_ones",    32'(bus.y_ones),    32'd0);
    chk("rst.acc_busy",  32'(bus.acc_busy),  32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);

    // back-to-back single beats, a=F0 b=3C
    ops    = '{3'd0, 3'd2, 3'd5, 3'd6};
    exp_sb = '{8'h30, 8'hCC, 8'h03, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'hF0, 8'h3C, ops[i], 1'b0, 1'b1);
      chk("b2b.y",         32'(bus.y),         32'(exp_sb[i]));
      chk("b2b.out_valid", 32'(bus.out_valid), 32'd1);
    end

    // back-pressure holds y and stalls input
    cycle(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b1);
    chk("bp.first", 32'(bus.y), 32'h30);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'hF0, 8'h3C, 3'd2, 1'b0, 1'b0);
      chk("bp.hold_y",   32'(bus.y),        32'h30);
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
    end
    cycle(1'b1, 8'hF0, 8'h3C, 3'd2, 1'b0, 1'b1);
    chk("bp.release_y", 32'(bus.y), 32'hCC);

    // flag boundaries
    cycle(1'b1, 8'h5A, 8'h5A, 3'd2, 1'b0, 1'b1);
    chk("flag.zero_y", 32'(bus.y),      32'h00);
    chk("flag.zero_z", 32'(bus.y_zero), 32'd1);
    chk("flag.zero_o", 32'(bus.y_ones), 32'd0);
    cycle(1'b1, 8'h5A, 8'h5A, 3'd3, 1'b0, 1'b1);
    chk("flag.ones_y", 32'(bus.y),      32'hFF);
    chk("flag.ones_o", 32'(bus.y_ones), 32'd1);
    chk("flag.ones_z", 32'(bus.y_zero), 32'd0);

    // accumulate frame: op latched on first beat, op input changed afterwards
    cycle(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b1);
    cycle(1'b1, 8'hFF, 8'h02, 3'd1, 1'b0, 1'b1);
    cycle(1'b1, 8'hFF, 8'h04, 3'd1, 1'b1, 1'b1);
`ifdef BOOLEAN_ALU_ACC_EN
    chk("acc.busy_mid",  32'(bus.acc_busy),  32'd1);
    chk("acc.no_output", 32'(bus.out_valid), 32'd0);
`else
    chk("noacc.busy",  32'(bus.acc_busy), 32'd0);
    chk("noacc.y_or",  32'(bus.y),        32'hFF);
`endif
    cycle(1'b1, 8'hFF, 8'h08, 3'd1, 1'b0, 1'b1);
`ifdef BOOLEAN_ALU_ACC_EN
    chk("acc.fold_y",    32'(bus.y),         32'h0F);
    chk("acc.busy_end",  32'(bus.acc_busy),  32'd0);
`endif
    chk("acc.out_valid", 32'(bus.out_valid), 32'd1);

    // asynchronous reset in the middle of a frame
    cycle(1'b1, 8'h0F, 8'h11, 3'd0, 1'b1, 1'b1);
    cycle(1'b1, 8'h0F, 8'h22, 3'd0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.acc_busy",  32'(bus.acc_busy),  32'd0);
    chk("arst.y",         32'(bus.y),         32'd0);
    #1 rst_n = 1'b1;
    cycle(1'b1, 8'h00, 8'h11, 3'd2, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'h00, 8'h22, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'h00, 8'h44, 3'd5, 1'b0, 1'b1);
    cycle(1'b1, 8'h00, 8'h88, 3'd6, 1'b0, 1'b1);
`ifdef BOOLEAN_ALU_ACC_EN
    chk("arst.fresh_fold", 32'(bus.y),      32'hFF);
    chk("arst.fresh_ones", 32'(bus.y_ones), 32'd1);
`endif

    // randomized streams with random back-pressure and frame requests
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
            3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0));
    end
    cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
